imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/loader_word_pack.sv | 39 +++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;

    // Explicit values keep the debug encoding stable across build options.
    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM   = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/loader_word_pack.sv
// Assembles little-endian bytes into one instruction word; the first byte
// pushed ends up in word[7:0]. last flags the final byte slot, full a completed word.
module loader_word_pack
    import imem_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    push,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    last,
    output logic                    full
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (push) begin
            // Shift right so earlier bytes settle into the low lanes.
            word <= {byte_in, word[8*WORD_BYTES-1:8]};
            cnt  <= cnt + 1'b1;
            full <= last;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: length header, little-endian words written to
// instruction memory, then releases the core. Option: IMEM_LOADER_CHECKSUM_EN.
//
// Handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready;
// rx_ready never depends on rx_valid, and the sender holds rx_data until then.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_run,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_ST = CSUM;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t           state, state_nxt;
    logic             armed;
    logic [7:0]       len_lo;
    logic [LEN_W-1:0] n_q;
    logic [LEN_W-1:0] k;
    logic [LEN_W-1:0] len_word;
    logic             accept;
    logic             pack_clear;
    logic             pack_last;
    logic             pack_full;
    logic             last_word;
    logic             rearm;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign len_word  = {rx_data, len_lo};
    assign last_word = (k == n_q - 1'b1);
    assign rearm     = start && (state == DONE || state == ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LEN_LO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pack_clear = 1'b0;
        case (state)
            LEN_LO: if (accept) state_nxt = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_word == '0)
                        state_nxt = END_ST;
                    else if (32'(len_word) > 32'(MAX_WORDS))
                        state_nxt = ERROR;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: if (accept && pack_last) state_nxt = WRITE;
            WRITE: begin
                pack_clear = 1'b1;
                state_nxt  = last_word ? END_ST : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (accept) state_nxt = (rx_data == csum) ? DONE : ERROR;
`endif
            DONE, ERROR: begin
                if (start) begin
                    state_nxt  = LEN_LO;
                    pack_clear = 1'b1;
                end
            end
            default: state_nxt = LEN_LO;
        endcase
    end

    // armed holds rx_ready low until the first edge after reset releases.
    always_comb begin
        rx_ready = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA: rx_ready = armed;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:                 rx_ready = armed;
`endif
            default:              rx_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed  <= 1'b0;
            len_lo <= '0;
            n_q    <= '0;
            k      <= '0;
        end else begin
            armed <= 1'b1;
            if (state == LEN_LO && accept) len_lo <= rx_data;
            if (state == LEN_HI && accept) n_q <= len_word;
            if (state == WRITE && !last_word) k <= k + 1'b1;
            if (rearm) k <= '0;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum <= '0;
        end else if (rearm) begin
            csum <= '0;
        end else if (state == DATA && accept) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    loader_word_pack u_pack (
        .clk     (clk),
        .reset   (reset),
        .clear   (pack_clear),
        .push    (state == DATA && accept),
        .byte_in (rx_data),
        .word    (imem_wdata),
        .last    (pack_last),
        .full    (pack_full)
    );

    assign imem_we   = (state == WRITE) && pack_full;
    assign imem_addr = BASE_ADDR + {{(32 - LEN_W - 2){1'b0}}, k, 2'b00};
    assign cpu_run   = (state == DONE);
    assign done      = (state == DONE);
    assign error     = (state == ERROR);
    assign state_dbg = state;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-stream model predicts every
// memory write and the final status. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam int          MAX_WORDS = 256;
    localparam int          LIMIT     = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];

    imem_loader #(.BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .done       (done),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: parse the stream by the protocol rules. st 0 = incomplete, 1 = done, 2 = error.
    function automatic void model(input logic [7:0] s[$], output int st);
        int n;
        int b;
        logic [7:0] x;
        st = 0;
        x  = 8'h00;
        if (s.size() < 2) return;
        n = int'(s[0]) + 256 * int'(s[1]);
        if (n > MAX_WORDS) begin
            st = 2;
            return;
        end
        for (int w = 0; w < n; w++) begin
            b = 2 + 4 * w;
            if (b + 3 >= s.size()) return;
            exp_q.push_back({32'(BASE_ADDR + 32'(4 * w)), s[b+3], s[b+2], s[b+1], s[b]});
            x = x ^ s[b] ^ s[b+1] ^ s[b+2] ^ s[b+3];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (s.size() > 2 + 4 * n) st = (s[2+4*n] == x) ? 1 : 2;
`else
        st = 1;
`endif
    endfunction

    function automatic void with_csum(inout logic [7:0] s[$]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < s.size(); i++) x = x ^ s[i];
        s.push_back(x);
`endif
    endfunction

    // Compare process: every write strobe must match the next modelled write.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {imem_addr, imem_wdata}, 64'hx);
            end else begin
                check("write", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
            check("rx_ready_in_write", 64'(rx_ready), 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tries    = 0;
        while (!rx_ready && tries < LIMIT) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_status(input string name, input int st);
        check({name, "_done"},    64'(done),    64'(st == 1));
        check({name, "_error"},   64'(error),   64'(st == 2));
        check({name, "_cpu_run"}, 64'(cpu_run), 64'(st == 1));
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_load(input string name, input logic [7:0] s[$], input int gap,
                            input bit mid_start);
        int st;
        model(s, st);
        for (int i = 0; i < s.size(); i++) begin
            send_byte(s[i], gap);
            if (mid_start && i == 1) pulse_start();
        end
        repeat (2) @(negedge clk);
        check_status(name, st);
    endtask

    task automatic rearm(input string name);
        pulse_start();
        check({name, "_done_clr"},  64'(done),     64'd0);
        check({name, "_error_clr"}, 64'(error),    64'd0);
        check({name, "_run_clr"},   64'(cpu_run),  64'd0);
        check({name, "_ready"},     64'(rx_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"},    64'(imem_we),  64'd0);
        check({name, "_addr"},  64'(imem_addr), 64'(BASE_ADDR));
        check({name, "_wdata"}, 64'(imem_wdata), 64'd0);
        check({name, "_run"},   64'(cpu_run),  64'd0);
        check({name, "_done"},  64'(done),     64'd0);
        check({name, "_error"}, 64'(error),    64'd0);
        check({name, "_ready"}, 64'(rx_ready), 64'd0);
    endtask

    initial begin
        logic [7:0] s[$];
        int st;

        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        #1;
        check("ready_before_edge", 64'(rx_ready), 64'd0);
        @(negedge clk);
        check("ready_after_edge", 64'(rx_ready), 64'd1);

        // Two-word program; pin the model against hand-computed writes first.
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        with_csum(s);
        model(s, st);
        check("pin_word0", exp_q[0], {32'h0000_0000, 32'h00A0_0513});
        check("pin_word1", exp_q[1], {32'h0000_0004, 32'h00B0_0593});
        check("pin_status", 64'(st), 64'd1);
        exp_q.delete();
        run_load("n2", s, 0, 1'b0);
        rearm("after_n2");

        s = '{8'h00, 8'h00};
        with_csum(s);
        run_load("n0", s, 0, 1'b0);
        rearm("after_n0");

        s = '{8'h01, 8'h01};
        model(s, st);
        check("pin_too_long", 64'(st), 64'd2);
        run_load("too_long", s, 0, 1'b0);
        check("too_long_ready", 64'(rx_ready), 64'd0);
        rearm("after_err");

        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        with_csum(s);
        run_load("n2_gapped", s, 1, 1'b0);
        rearm("after_gapped");

        // Largest legal length; a start pulse mid-load must be ignored.
        s = '{8'h00, 8'h01};
        for (int j = 0; j < 4 * MAX_WORDS; j++) s.push_back(8'((j * 7 + 3) & 255));
        with_csum(s);
        run_load("max_words", s, 0, 1'b1);
        rearm("after_max");

        // Reset in the middle of word 0: the partial word must vanish.
        s = '{8'h02, 8'h00, 8'h13, 8'h05};
        for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        with_csum(s);
        model(s, st);
        check("pin_n1", exp_q[0], {BASE_ADDR, 32'h1234_5678});
        exp_q.delete();
        run_load("n1_after_reset", s, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        rearm("before_csum_ok");
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        run_load("csum_ok", s, 0, 1'b0);
        rearm("before_csum_bad");
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        model(s, st);
        check("pin_csum_bad", 64'(st), 64'd2);
        exp_q.delete();
        run_load("csum_bad", s, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
